// File: rtl/dev_bus_arbiter.sv
// Two-master fixed-priority arbiter in front of the timer/memory bridge port.
// Define ARB_AGING_EN to add the master-1 anti-starvation aging counter.
module dev_bus_arbiter #(
  parameter int STARVE_LIMIT = 8,
  parameter int AGE_W        = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_byteen,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_byteen,
  output logic        m0_gnt,
  output logic        m1_gnt,
  output logic        m0_rvalid,
  output logic        m1_rvalid,
  output logic [31:0] m_rdata,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_byteen,
  output logic        bus_rd,
  input  logic [31:0] bus_rdata,
  output logic        busy
);
  localparam int NUM_M = 2;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  byteen;
  } req_t;

  state_t              state_q, state_d;
  req_t [NUM_M-1:0]    rq;
  logic [NUM_M-1:0]    req, gnt, rvalid;
  logic                owner_q;
  logic [3:0]          byteen_q;
  logic                arb, win, winner, force_m1;

  assign req   = {m1_req, m0_req};
  assign rq[0] = {m0_addr, m0_wdata, m0_byteen};
  assign rq[1] = {m1_addr, m1_wdata, m1_byteen};

  // Arbitration only on edges leaving IDLE or RESP; req is ignored in ISSUE.
  assign arb    = (state_q == IDLE) || (state_q == RESP);
  assign win    = arb && (|req);
  assign winner = force_m1 || (!m0_req && m1_req);

`ifdef ARB_AGING_EN
  logic [AGE_W-1:0] age_q;

  assign force_m1 = m1_req && (age_q == AGE_W'(STARVE_LIMIT));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                    age_q <= '0;
    else if (arb) begin
      if (!m1_req || winner)       age_q <= '0;
      else if (age_q != '1)        age_q <= age_q + 1'b1;
    end
  end
`else
  // Aging parameters have no effect in the fixed-priority build.
  logic unused_cfg;
  assign unused_cfg = ^{32'(STARVE_LIMIT), 32'(AGE_W)};
  assign force_m1   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, RESP: state_d = win ? ISSUE : IDLE;
      ISSUE:      state_d = RESP;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      byteen_q  <= '0;
      bus_addr  <= '0;
      bus_wdata <= '0;
    end else begin
      state_q <= state_d;
      if (win) begin
        owner_q   <= winner;
        bus_addr  <= rq[winner].addr;
        bus_wdata <= rq[winner].wdata;
        byteen_q  <= rq[winner].byteen;
      end
    end
  end

  for (genvar i = 0; i < NUM_M; i++) begin : g_port
    assign gnt[i]    = (state_q == ISSUE) && (owner_q == 1'(i));
    assign rvalid[i] = (state_q == RESP)  && (owner_q == 1'(i));
  end

  assign m0_gnt     = gnt[0];
  assign m1_gnt     = gnt[1];
  assign m0_rvalid  = rvalid[0];
  assign m1_rvalid  = rvalid[1];
  assign bus_byteen = (state_q == ISSUE) ? byteen_q : 4'b0000;
  assign bus_rd     = (state_q == ISSUE) && (byteen_q == 4'b0000);
  assign m_rdata    = (state_q == RESP) ? bus_rdata : 32'h0;
  assign busy       = (state_q != IDLE);
endmodule
